ctrl_pipe: RTL
==============

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter CTRL_W, default 9, meaning width of the packed control word.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the bubble counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 id_ctrl  input  CTRL_W  packed control word from the decode stage.
REQ-006 id_valid  input  1  the decode stage holds a real instruction.
REQ-007 id_rs, id_rt, id_rd  input  5 each  register specifiers of the decode-stage instruction.
REQ-008 branch_taken  input  1  the MEM-stage branch resolved taken.
REQ-009 cache_stall  input  1  memory hierarchy busy; freeze pipe.
REQ-010 hazard_stall  output  1  tells PC and IF/ID to hold.
REQ-011 ex_regdst, ex_alusrc, ex_rtype, ex_beq  output  1 each  EX-stage controls.
REQ-012 mem_branch, mem_read, mem_write  output  1 each  MEM-stage controls.
REQ-013 wb_memtoreg, wb_regwrite  output  1 each  WB-stage controls.
REQ-014 wb_dst  output  5  WB destination register.
REQ-015 ex_valid, mem_valid, wb_valid  output  1 each  stage holds a real instruction.
REQ-016 bubble_cnt  output  CNT_W  count of load-use bubbles inserted.

Function
REQ-017 Control word layout SHALL be: [8] memtoreg, [7] regwrite, [6] branch, [5] memread, [4] memwrite, [3] regdst, [2] alusrc, [1] rtype, [0] beq.
REQ-018 Three stage registers (EX, MEM, WB) SHALL each hold valid, the control word, and the stage's register fields. EX holds rs/rt/rd; MEM and WB hold dst.
REQ-019 dst SHALL be computed when leaving EX: rd if regdst=1, else rt.
REQ-020 Every control output SHALL equal its stage field ANDed with that stage's valid.
REQ-021 hazard_stall SHALL be combinational: id_valid & ex_valid & ex memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
REQ-022 Update priority SHALL be: cache_stall > branch_taken > hazard_stall > normal advance.
REQ-023 cache_stall: all stage registers and bubble_cnt hold; wb_regwrite forced 0 to prevent duplicate writes.
REQ-024 branch_taken (no cache_stall): EX and MEM load bubbles (valid=0, ctrl=0); WB loads MEM.
REQ-025 hazard_stall (no cache_stall or branch_taken): EX loads a bubble; MEM loads EX; WB loads MEM; bubble_cnt increments, saturating at all-ones.
REQ-026 Normal advance: EX loads id_ctrl and id fields, or a bubble if id_valid=0; MEM loads EX; WB loads MEM.
REQ-027 Latency SHALL be 1 cycle from id_ctrl to EX outputs, 2 cycles to MEM outputs, and 3 cycles to WB outputs, absent stalls or flushes.
REQ-028 Simultaneous branch_taken and hazard_stall SHALL flush only; bubble_cnt does not increment.

Reset
REQ-029 While rst=1, all valid bits, control words, register fields, wb_dst and bubble_cnt SHALL be 0, and all control outputs and hazard_stall SHALL read 0.
REQ-030 rst asserted mid-operation SHALL discard all in-flight instructions immediately.
REQ-031 The first edge after rst deasserts SHALL apply the normal update rules.

Structure
REQ-032 A shared package SHALL hold CTRL_W, the nine bit-index constants, and the stage-register record type.
REQ-033 One sub-module, ctrl_stage_reg, SHALL implement a single stage register with hold and bubble inputs, instantiated three times.

Verification
REQ-034 Stream lw 0x1A4, R 0x08A, sw 0x014 (no dependency) -> each appears on EX/MEM/WB outputs at +1/+2/+3 cycles; bubble_cnt=0.
REQ-035 lw rt=5, then R rs=5 -> hazard_stall=1 for one cycle; one bubble at MEM; bubble_cnt=1; R reaches WB with wb_dst=rd.
REQ-036 lw rt=0, then R rs=0 -> hazard_stall stays 0.
REQ-037 beq 0x041 in MEM with branch_taken=1 -> next cycle ex_valid=0 and mem_valid=0; wb_valid=1 with the beq word.
REQ-038 cache_stall=1 for 3 cycles with R in WB -> all outputs frozen and wb_regwrite=0; after release, wb_regwrite=1 for exactly one cycle.
REQ-039 Preload bubble_cnt to 0xFFFF via repeated hazards -> it stays 0xFFFF; rst pulse mid-stream clears all valids and the counter asynchronously.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the EX/MEM/WB control pipeline: control-word layout,
// the stage-register record and a helper that resolves the WB destination.
package ctrl_pipe_pkg;

  localparam int CTRL_W = 9;
  localparam int REG_W  = 5;

  // Bit positions inside the packed control word.
  localparam int B_MEMTOREG = 8;
  localparam int B_REGWRITE = 7;
  localparam int B_BRANCH   = 6;
  localparam int B_MEMREAD  = 5;
  localparam int B_MEMWRITE = 4;
  localparam int B_REGDST   = 3;
  localparam int B_ALUSRC   = 2;
  localparam int B_RTYPE    = 1;
  localparam int B_BEQ      = 0;

  // One record type for all three stages. EX uses rs/rt/rd; MEM and WB only
  // carry dst, which is resolved as the instruction leaves EX.
  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  dst;
  } stage_t;

  localparam int STAGE_W = $bits(stage_t);

  // Destination register chosen when an instruction leaves EX.
  function automatic logic [REG_W-1:0] pick_dst(input stage_t s);
    return s.ctrl[B_REGDST] ? s.rd : s.rt;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// Single pipeline stage register. Hold freezes the contents, bubble loads an
// all-zero record (valid=0, ctrl=0), otherwise the upstream record is taken.
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               bubble,
  input  logic [STAGE_W-1:0] d,
  output logic [STAGE_W-1:0] q
);

  // Stage register: hold beats bubble, bubble beats load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control pipeline with load-use hazard detection, branch flush,
// cache freeze and a saturating count of load-use bubbles.
module ctrl_pipe #(
  parameter int CTRL_W = ctrl_pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              branch_taken,
  input  logic              cache_stall,
  output logic              hazard_stall,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic              ex_rtype,
  output logic              ex_beq,
  output logic              mem_branch,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_memtoreg,
  output logic              wb_regwrite,
  output logic [4:0]        wb_dst,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  bubble_cnt
);

  import ctrl_pipe_pkg::*;

  stage_t ex_d, ex_q;
  stage_t mem_d, mem_q;
  stage_t wb_q;
  logic   ex_bubble;
  logic   mem_bubble;
  logic   unused_fields;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  assign hazard_stall = id_valid & ex_q.valid & ex_q.ctrl[B_MEMREAD]
                      & (ex_q.rt != 5'd0)
                      & ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));

  // A flush or a load-use stall both put a bubble into EX; so does an empty ID.
  assign ex_bubble  = branch_taken | hazard_stall | ~id_valid;
  assign mem_bubble = branch_taken;

  // Record entering EX from the decode stage.
  always_comb begin
    ex_d       = '0;
    ex_d.valid = 1'b1;
    ex_d.ctrl  = id_ctrl;
    ex_d.rs    = id_rs;
    ex_d.rt    = id_rt;
    ex_d.rd    = id_rd;
  end

  // Record entering MEM: register fields collapse to the resolved destination.
  always_comb begin
    mem_d       = '0;
    mem_d.valid = ex_q.valid;
    mem_d.ctrl  = ex_q.ctrl;
    mem_d.dst   = pick_dst(ex_q);
  end

  ctrl_stage_reg u_ex (
    .clk    (clk),
    .rst    (rst),
    .hold   (cache_stall),
    .bubble (ex_bubble),
    .d      (ex_d),
    .q      (ex_q)
  );

  ctrl_stage_reg u_mem (
    .clk    (clk),
    .rst    (rst),
    .hold   (cache_stall),
    .bubble (mem_bubble),
    .d      (mem_d),
    .q      (mem_q)
  );

  ctrl_stage_reg u_wb (
    .clk    (clk),
    .rst    (rst),
    .hold   (cache_stall),
    .bubble (1'b0),
    .d      (mem_q),
    .q      (wb_q)
  );

  // Register fields that no later logic reads; folded so they do not read as dead logic.
  assign unused_fields = ^{ex_q.dst, mem_q.rs, mem_q.rt, mem_q.rd,
                           wb_q.rs, wb_q.rt, wb_q.rd};

  // Count inserted load-use bubbles; flushes and freezes do not count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!cache_stall && !branch_taken && hazard_stall
                 && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign ex_valid  = ex_q.valid;
  assign mem_valid = mem_q.valid;
  assign wb_valid  = wb_q.valid;

  assign ex_regdst = ex_q.valid & ex_q.ctrl[B_REGDST];
  assign ex_alusrc = ex_q.valid & ex_q.ctrl[B_ALUSRC];
  assign ex_rtype  = ex_q.valid & ex_q.ctrl[B_RTYPE];
  assign ex_beq    = ex_q.valid & ex_q.ctrl[B_BEQ];

  assign mem_branch = mem_q.valid & mem_q.ctrl[B_BRANCH];
  assign mem_read   = mem_q.valid & mem_q.ctrl[B_MEMREAD];
  assign mem_write  = mem_q.valid & mem_q.ctrl[B_MEMWRITE];

  // A frozen WB instruction must not write the register file on every stalled cycle.
  assign wb_memtoreg = wb_q.valid & wb_q.ctrl[B_MEMTOREG];
  assign wb_regwrite = wb_q.valid & wb_q.ctrl[B_REGWRITE] & ~cache_stall;
  assign wb_dst      = wb_q.dst;

endmodule
